seg2hex_capture: RTL and testbench

Receive side of the multiplexed seven-segment digit bus driven by our hex-to-segment encoder. Samples the scanned digit index `sel` and segment pattern `seg_d`, debounces each pair, and inverts the encoding back to a nibble. Four captured digits are assembled into a 16-bit word and presented on a valid/ready output. Sits in test/loopback logic and in boards that snoop a display bus.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg_pattern_dec.sv | 22 ++
 rtl/seg2hex_capture.sv | 164 ++++++++++++++++
 tb/tb_seg2hex_capture.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment digit bus: segment codes, blank and
// marker patterns, digit count, output-register state and the code lookup.
package seg_pkg;

  localparam int DIGITS = 4;

  localparam logic [7:0] SEG_MARKER = 8'h49;
  localparam logic [7:0] SEG_BLANK  = 8'h00;

  localparam logic [6:0] SEG_0 = 7'h3f;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5b;
  localparam logic [6:0] SEG_3 = 7'h4f;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6d;
  localparam logic [6:0] SEG_6 = 7'h7d;
  localparam logic [6:0] SEG_7 = 7'h27;
  localparam logic [6:0] SEG_8 = 7'h7f;
  localparam logic [6:0] SEG_9 = 7'h6f;
  localparam logic [6:0] SEG_A = 7'h5f;
  localparam logic [6:0] SEG_B = 7'h7c;
  localparam logic [6:0] SEG_C = 7'h58;
  localparam logic [6:0] SEG_D = 7'h5e;
  localparam logic [6:0] SEG_E = 7'h7b;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Returns {hit, value}; hit is 0 for any pattern outside the code table.
  function automatic logic [4:0] seg_lookup(input logic [6:0] seg);
    case (seg)
      SEG_0:   return {1'b1, 4'h0};
      SEG_1:   return {1'b1, 4'h1};
      SEG_2:   return {1'b1, 4'h2};
      SEG_3:   return {1'b1, 4'h3};
      SEG_4:   return {1'b1, 4'h4};
      SEG_5:   return {1'b1, 4'h5};
      SEG_6:   return {1'b1, 4'h6};
      SEG_7:   return {1'b1, 4'h7};
      SEG_8:   return {1'b1, 4'h8};
      SEG_9:   return {1'b1, 4'h9};
      SEG_A:   return {1'b1, 4'ha};
      SEG_B:   return {1'b1, 4'hb};
      SEG_C:   return {1'b1, 4'hc};
      SEG_D:   return {1'b1, 4'hd};
      SEG_E:   return {1'b1, 4'he};
      SEG_F:   return {1'b1, 4'hf};
      default: return 5'b0_0000;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational segment-pattern decoder: inverts the code table and removes
// the encoder's per-digit offset (value - sel mod 16).
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  input  logic [1:0] sel,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       is_blank,
  output logic       is_marker
);

  logic [4:0] look;

  assign look      = seg_lookup(seg);
  assign hit       = look[4];
  assign nibble    = look[3:0] - {2'b00, sel};
  assign is_blank  = (seg == SEG_BLANK[6:0]);
  assign is_marker = (seg == SEG_MARKER[6:0]);

endmodule

// File: rtl/seg2hex_capture.sv
// Seven-segment bus snooper: debounces {sel, seg_d}, decodes four digits into a
// 16-bit word on a valid/ready output. Define SEG2HEX_DP_CAPTURE_EN to capture dp.
module seg2hex_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic [7:0]  seg_d,
  input  logic        ovr_clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic [3:0]  dp_out,
  output logic        err,
  output logic        ovr
);

  localparam logic [7:0] ACC_CNT = 8'(STABLE_CYC - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  logic [2:0]        sel_p0;
  logic [7:0]        seg_p0;
  logic [7:0]        cnt_p0;
  logic              acc;
  logic [3:0]        nibble;
  logic              hit, is_blank, is_marker, dp_bad;
  logic              bad, wr_digit, frame_done, load, drop;
  logic [DIGITS-1:0] mask_p1, mask_upd;
  logic [15:0]       word_p1, word_upd;
  out_state_t        state_q, state_d;

  // ---- p0: input sample and stability counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_p0 <= '0;
      seg_p0 <= '0;
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= ({sel, seg_d} != {sel_p0, seg_p0}) ? 8'd0 : sat_inc(cnt_p0);
      sel_p0 <= sel;
      seg_p0 <= seg_d;
    end
  end

  // Saturation keeps cnt from wrapping back onto ACC_CNT, so one pulse per run.
  assign acc = (cnt_p0 == ACC_CNT);

  seg_pattern_dec u_dec (
    .seg       (seg_p0[6:0]),
    .sel       (sel_p0[1:0]),
    .nibble    (nibble),
    .hit       (hit),
    .is_blank  (is_blank),
    .is_marker (is_marker)
  );

`ifdef SEG2HEX_DP_CAPTURE_EN
  assign dp_bad = 1'b0;
`else
  assign dp_bad = seg_p0[7];
`endif

  always_comb begin
    wr_digit = 1'b0;
    bad      = 1'b0;
    if (acc) begin
      if (dp_bad) begin
        bad = 1'b1;
      end else if (!is_blank) begin
        if (!sel_p0[2] && hit)
          wr_digit = 1'b1;
        else if (!(sel_p0[2] && is_marker))
          bad = 1'b1;
      end
    end
  end

  always_comb begin
    mask_upd = mask_p1;
    word_upd = word_p1;
    if (bad) begin
      mask_upd = '0;
    end else if (wr_digit) begin
      mask_upd[sel_p0[1:0]]              = 1'b1;
      word_upd[{sel_p0[1:0], 2'b00} +: 4] = nibble;
    end
  end

  assign frame_done = (mask_upd == '1);

  // ---- p1: digit capture, output register and flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    if (frame_done) begin
      if (state_q == OUT_EMPTY || out_ready) begin
        load    = 1'b1;
        state_d = OUT_FULL;
      end else begin
        drop = 1'b1;
      end
    end else if (state_q == OUT_FULL && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == OUT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_p1 <= '0;
      err     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      mask_p1 <= frame_done ? '0 : mask_upd;
      err     <= bad;
      ovr     <= drop | (ovr & ~ovr_clr);
    end
  end

  always_ff @(posedge clk) begin
    word_p1 <= word_upd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_out <= '0;
    else if (load) data_out <= word_upd;
  end

`ifdef SEG2HEX_DP_CAPTURE_EN
  logic [DIGITS-1:0] dpm_p1, dpm_upd;

  always_comb begin
    dpm_upd = dpm_p1;
    if (wr_digit) dpm_upd[sel_p0[1:0]] = seg_p0[7];
  end

  always_ff @(posedge clk) begin
    dpm_p1 <= dpm_upd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dp_out <= '0;
    else if (load) dp_out <= dpm_upd;
  end
`else
  assign dp_out = '0;
`endif

endmodule

// File: tb/tb_seg2hex_capture.sv
// Bench for seg2hex_capture: directed scenarios plus random bus traffic, checked
// every cycle against an event-level reference model.
module tb_seg2hex_capture;

  localparam int S = 4;
`ifdef SEG2HEX_DP_CAPTURE_EN
  localparam bit DPCAP = 1'b1;
`else
  localparam bit DPCAP = 1'b0;
`endif
  localparam logic [6:0] CODES [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
                                        7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic [7:0]  seg_d = '0;
  logic        ovr_clr = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] data_out;
  logic [3:0]  dp_out;
  logic        err;
  logic        ovr;

  int n_chk  = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  logic [15:0] last_word = '0;

  seg2hex_capture #(.STABLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .seg_d     (seg_d),
    .ovr_clr   (ovr_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .dp_out    (dp_out),
    .err       (err),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many consecutive edges each pair was sampled,
  // and applies an accepted pair on the edge after its S-th sample.
  int          run;
  logic [10:0] prev_pair, pend_pair;
  bit          pend;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dpd, m_mask, m_dp;
  bit          m_full, m_err, m_ovr;
  logic [15:0] m_data;

  function automatic int lookup(input logic [6:0] c);
    for (int i = 0; i < 16; i++)
      if (CODES[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    run = 1; prev_pair = '0; pend_pair = '0; pend = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    m_dpd = '0; m_mask = '0; m_dp = '0;
    m_full = 0; m_err = 0; m_ovr = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit done = 0, bad = 0, set_ovr = 0;
    int s, v;
    logic [7:0] p;
    logic [10:0] cur;
    if (pend) begin
      s = int'(pend_pair[10:8]);
      p = pend_pair[7:0];
      v = lookup(p[6:0]);
      if (!DPCAP && p[7]) bad = 1;
      else if (p[6:0] == 7'h00) bad = 0;
      else if (s < 4 && v >= 0) begin
        m_dig[s] = 4'((v - s) & 15);
        m_dpd[s] = p[7];
        m_mask[s] = 1'b1;
      end else if (s >= 4 && p[6:0] == 7'h49) bad = 0;
      else bad = 1;
      if (bad) m_mask = '0;
      if (m_mask == 4'hf) begin done = 1; m_mask = '0; end
    end
    m_err = bad;
    if (done && (!m_full || out_ready)) begin
      m_full = 1;
      m_data = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      m_dp   = DPCAP ? m_dpd : 4'h0;
    end else begin
      if (done) set_ovr = 1;
      if (m_full && out_ready) m_full = 0;
    end
    if (set_ovr) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    cur = {sel, seg_d};
    if (cur == prev_pair) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
      prev_pair = cur;
    end
    pend = (run == S);
    pend_pair = cur;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) check("data_out", 32'(data_out), 32'(m_data));
        check("dp_out", 32'(dp_out), 32'(m_dp));
        check("err", 32'(err), 32'(m_err));
        check("ovr", 32'(ovr), 32'(m_ovr));
        if (out_valid && out_ready) begin
          hs_cnt++;
          last_word = data_out;
        end
        if (err) err_cnt++;
      end
    end
  end

  task automatic drive(input logic [2:0] s, input logic [7:0] p, input int n);
    sel = s;
    seg_d = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
    drive(3'd0, p0, 6);
    drive(3'd1, p1, 6);
    drive(3'd2, p2, 6);
    drive(3'd3, p3, 6);
    drive(3'd4, 8'h49, 6);
  endtask

  initial begin
    int hs0, e0, n, u;
    logic [7:0] p;
    logic [2:0] s;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset dp_out", 32'(dp_out), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset ovr", 32'(ovr), 32'h0);
    rst = 1'b0;
    drive(3'd4, 8'h49, 3);

    // Straight frame
    hs0 = hs_cnt;
    frame4(8'h3f, 8'h5b, 8'h7d, 8'h6f);
    check("straight words", 32'(hs_cnt - hs0), 32'd1);
    check("straight word", 32'(last_word), 32'h6410);

    // Glitch rejection: a 3-cycle hold on sel=1 must not set its digit
    hs0 = hs_cnt;
    drive(3'd1, 8'h06, 3);
    drive(3'd4, 8'h49, 6);
    drive(3'd0, 8'h3f, 6);
    drive(3'd2, 8'h7d, 6);
    drive(3'd3, 8'h6f, 6);
    drive(3'd4, 8'h49, 6);
    check("glitch no word", 32'(hs_cnt - hs0), 32'd0);
    drive(3'd1, 8'h06, 6);
    drive(3'd4, 8'h49, 6);
    check("glitch then word", 32'(hs_cnt - hs0), 32'd1);
    check("glitch word", 32'(last_word), 32'h6400);

    // Invalid pattern clears the partial frame
    hs0 = hs_cnt; e0 = err_cnt;
    drive(3'd0, 8'h3f, 6);
    drive(3'd1, 8'h06, 6);
    drive(3'd2, 8'h49, 4);
    drive(3'd4, 8'h49, 6);
    check("invalid err pulses", 32'(err_cnt - e0), 32'd1);
    drive(3'd2, 8'h7d, 6);
    drive(3'd3, 8'h6f, 6);
    drive(3'd4, 8'h49, 6);
    check("invalid mask cleared", 32'(hs_cnt - hs0), 32'd0);
    drive(3'd0, 8'h3f, 6);
    drive(3'd1, 8'h06, 6);
    drive(3'd4, 8'h49, 6);
    check("invalid then word", 32'(last_word), 32'h6400);

    // Marker slots
    e0 = err_cnt;
    drive(3'd5, 8'h49, 6);
    check("marker no err", 32'(err_cnt - e0), 32'd0);
    drive(3'd6, 8'h3f, 6);
    drive(3'd4, 8'h49, 6);
    check("slot6 err", 32'(err_cnt - e0), 32'd1);
    drive(3'd0, 8'hbf, 6);
    drive(3'd4, 8'h49, 6);
    check("dp bit err", 32'(err_cnt - e0), DPCAP ? 32'd1 : 32'd2);

    // Overrun
    out_ready = 1'b0;
    frame4(8'h3f, 8'h3f, 8'h3f, 8'h3f);
    frame4(8'h7f, 8'h7f, 8'h7f, 8'h7f);
    check("overrun held valid", 32'(out_valid), 32'h1);
    check("overrun held word", 32'(data_out), 32'hdef0);
    check("overrun ovr", 32'(ovr), 32'h1);
    drive(3'd0, 8'h06, 6);
    drive(3'd1, 8'h06, 6);
    drive(3'd2, 8'h06, 6);
    drive(3'd3, 8'h06, S);
    ovr_clr = 1'b1;
    drive(3'd3, 8'h06, 1);
    ovr_clr = 1'b0;
    check("set beats clear", 32'(ovr), 32'h1);
    ovr_clr = 1'b1;
    drive(3'd4, 8'h49, 1);
    ovr_clr = 1'b0;
    check("ovr cleared", 32'(ovr), 32'h0);
    hs0 = hs_cnt;
    out_ready = 1'b1;
    drive(3'd4, 8'h49, 3);
    check("overrun drain word", 32'(last_word), 32'hdef0);
    check("overrun drain count", 32'(hs_cnt - hs0), 32'd1);

    // Reset mid-frame
    drive(3'd0, 8'h06, 6);
    drive(3'd1, 8'h5b, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs0 = hs_cnt;
    drive(3'd2, 8'h7f, 6);
    drive(3'd3, 8'h7f, 6);
    drive(3'd4, 8'h49, 6);
    check("reset discards digits", 32'(hs_cnt - hs0), 32'd0);
    frame4(8'h7f, 8'h7f, 8'h7f, 8'h7f);
    check("post-reset words", 32'(hs_cnt - hs0), 32'd1);
    check("post-reset word", 32'(last_word), 32'h5678);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      u = $urandom_range(0, 9);
      s = (u < 7) ? 3'(u % 4) : 3'($urandom_range(0, 7));
      u = $urandom_range(0, 9);
      if (u < 6)       p = {($urandom_range(0, 15) == 0), CODES[$urandom_range(0, 15)]};
      else if (u == 6) p = 8'h00;
      else if (u == 7) p = 8'h49;
      else             p = 8'($urandom);
      sel = s;
      seg_d = p;
      n = $urandom_range(1, 7);
      for (int c = 0; c < n; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ovr_clr = ($urandom_range(0, 15) == 0);
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    ovr_clr = 1'b0;
    drive(3'd4, 8'h49, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
